// File: rtl/uart_fifo_wb_if.sv
// Bus-side signal bundle for the uart_fifo_wb Wishbone-style slave.
interface uart_fifo_wb_if;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_in;
  logic [7:0] wb_data_out;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;

  modport master (output wb_addr, wb_data_in, wb_we, wb_stb, input wb_data_out, wb_ack);
  modport slave  (input wb_addr, wb_data_in, wb_we, wb_stb, output wb_data_out, wb_ack);
endinterface

// File: rtl/uart_fifo_wb.sv
// Full-duplex UART with TX/RX FIFOs, programmable divisor, sticky error flags and irq,
// behind a single-clock Wishbone-style register slave.
module uart_fifo_wb #(
  parameter int CLK_HZ       = 12000000,
  parameter int DEFAULT_BAUD = 115200,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_fifo_wb_if.slave bus,
  output logic          tx_bit,
  input  logic          rx_bit,
  output logic          irq
);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              BW       = $clog2(DATA_BITS);
  localparam logic [15:0]     DIV_RST  = 16'(CLK_HZ / DEFAULT_BAUD - 1);
  localparam logic [BW-1:0]   IDX_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]     PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic                 ack_q, ack_d, irq_q, irq_d;
  logic [7:0]           dout_q, dout_d;
  logic [15:0]          div_q, div_d, div_eff;
  logic                 txovf_q, txovf_d, rxovr_q, rxovr_d, frerr_q, frerr_d;
  logic [AW:0]          tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [DATA_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem_q [FIFO_DEPTH];

  state_e               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [BW-1:0]        tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic                 tx_out_q, tx_out_d;
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;

  logic       acc, wr_en, rd_en;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       txovf_set, rxovr_set, frerr_set, w1c_sel, rx_fall;
  logic [7:0] status, rdata;

  // A held strobe only re-qualifies after ack drops, so each ack carries one side effect.
  assign acc   = bus.wb_stb & ~ack_q;
  assign wr_en = acc & bus.wb_we;
  assign rd_en = acc & ~bus.wb_we;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);

  assign tx_push   = wr_en && bus.wb_addr == 2'd0 && !tx_full;
  assign txovf_set = wr_en && bus.wb_addr == 2'd0 && tx_full;
  assign rx_pop    = rd_en && bus.wb_addr == 2'd0 && !rx_empty;
  assign w1c_sel   = wr_en && bus.wb_addr == 2'd1;

  assign div_eff = (div_q < 16'd3) ? 16'd3 : div_q;
  assign status  = {txovf_q, tx_state_q != S_IDLE, frerr_q, rxovr_q, rx_full, ~rx_empty, tx_empty, tx_full};

  assign bus.wb_ack      = ack_q;
  assign bus.wb_data_out = dout_q;
  assign tx_bit          = tx_out_q;
  assign irq             = irq_q;

  always_comb begin
    rdata = '0;
    case (bus.wb_addr)
      2'd0:    if (!rx_empty) rdata[DATA_BITS-1:0] = rx_mem_q[rx_rp_q[AW-1:0]];
      2'd1:    rdata = status;
      2'd2:    rdata = div_q[7:0];
      default: rdata = div_q[15:8];
    endcase
  end

  always_comb begin
    ack_d   = bus.wb_stb & ~ack_q;
    dout_d  = rd_en ? rdata : 8'h00;
    div_d   = div_q;
    if (wr_en && bus.wb_addr == 2'd2) div_d[7:0]  = bus.wb_data_in;
    if (wr_en && bus.wb_addr == 2'd3) div_d[15:8] = bus.wb_data_in;
    txovf_d = txovf_set | (txovf_q & ~(w1c_sel & bus.wb_data_in[7]));
    rxovr_d = rxovr_set | (rxovr_q & ~(w1c_sel & bus.wb_data_in[4]));
    frerr_d = frerr_set | (frerr_q & ~(w1c_sel & bus.wb_data_in[5]));
    irq_d   = ~rx_empty | rxovr_q | frerr_q | txovf_q;
    tx_wp_d = tx_wp_q + (tx_push ? PTR_ONE : '0);
    tx_rp_d = tx_rp_q + (tx_pop  ? PTR_ONE : '0);
    rx_wp_d = rx_wp_q + (rx_push ? PTR_ONE : '0);
    rx_rp_d = rx_rp_q + (rx_pop  ? PTR_ONE : '0);
  end

  // TX: the shifter keeps the current bit in [0]; STOP chains straight into the next START.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_sh_d    = tx_sh_q;
    tx_idx_d   = tx_idx_q;
    tx_out_d   = tx_out_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_mem_q[tx_rp_q[AW-1:0]];
          tx_div_d   = div_eff;
          tx_state_d = S_START;
          tx_out_d   = 1'b0;
        end
      end
      S_START: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = S_DATA;
        tx_out_d   = tx_sh_q[0];
      end
      S_DATA: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d = '0;
        if (tx_idx_q == IDX_LAST) begin
          tx_state_d = S_STOP;
          tx_out_d   = 1'b1;
        end else begin
          tx_idx_d = tx_idx_q + BW'(1);
          tx_sh_d  = tx_sh_q >> 1;
          tx_out_d = tx_sh_q[1];
        end
      end
      default: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_mem_q[tx_rp_q[AW-1:0]];
          tx_div_d   = div_eff;
          tx_state_d = S_START;
          tx_out_d   = 1'b0;
        end else begin
          tx_state_d = S_IDLE;
          tx_out_d   = 1'b1;
        end
      end
    endcase
  end

  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign rx_half = 16'({1'b0, rx_div_q[15:1]}) + {15'd0, rx_div_q[0]};

  always_comb begin
    rx_s1_d    = rx_bit;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_sh_d    = rx_sh_q;
    rx_idx_d   = rx_idx_q;
    rx_push    = 1'b0;
    rxovr_set  = 1'b0;
    frerr_set  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_div_d   = div_eff;
          rx_state_d = S_START;
        end
      end
      S_START: if (rx_cnt_q == rx_half) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_idx_q == IDX_LAST) rx_state_d = S_STOP;
        else                      rx_idx_d   = rx_idx_q + BW'(1);
      end
      default: if (rx_cnt_q == rx_div_q) begin
        rx_state_d = S_IDLE;
        if (!rx_s2_q)     frerr_set = 1'b1;
        else if (rx_full) rxovr_set = 1'b1;
        else              rx_push   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= bus.wb_data_in[DATA_BITS-1:0];
    if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q      <= 1'b0;
      dout_q     <= '0;
      irq_q      <= 1'b0;
      div_q      <= DIV_RST;
      txovf_q    <= 1'b0;
      rxovr_q    <= 1'b0;
      frerr_q    <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= '0;
      tx_sh_q    <= '0;
      tx_idx_q   <= '0;
      tx_out_q   <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= '0;
      rx_sh_q    <= '0;
      rx_idx_q   <= '0;
    end else begin
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      irq_q      <= irq_d;
      div_q      <= div_d;
      txovf_q    <= txovf_d;
      rxovr_q    <= rxovr_d;
      frerr_q    <= frerr_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_sh_q    <= tx_sh_d;
      tx_idx_q   <= tx_idx_d;
      tx_out_q   <= tx_out_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_sh_q    <= rx_sh_d;
      rx_idx_q   <= rx_idx_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo_wb.sv
// Scoreboard bench for uart_fifo_wb: bus reads and TX frames are checked against
// expectations queued from a queue-based model of the registers, FIFOs and flags.
module tb_uart_fifo_wb;
  localparam int DEPTH = 16;
  localparam int DBITS = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  logic tx_bit, irq, rx_bit;

  uart_fifo_wb_if bus();
  assign rx_bit = loop_en ? tx_bit : rx_drv;

  uart_fifo_wb #(.CLK_HZ(12000000), .DEFAULT_BAUD(115200), .FIFO_DEPTH(DEPTH), .DATA_BITS(DBITS)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .tx_bit(tx_bit), .rx_bit(rx_bit), .irq(irq));

  always #5 clk = ~clk;

  typedef struct { bit is_rd; logic [7:0] val; string nm; } rd_exp_t;
  rd_exp_t    rd_q[$];
  logic [7:0] tx_exp[$];
  int         tx_starts[$];
  logic [7:0] rxm[$];
  bit         m_txovf = 0, m_rxovr = 0, m_frerr = 0;
  int         m_txq = 0;
  int         checks = 0, errors = 0, cyc = 0, tb_p = 8;
  bit         tx_mon_en = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Read monitor: every ack consumes one queued expectation.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wb_ack === 1'b1) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: data_out 0x%02h with nothing queued", bus.wb_data_out);
        end else begin
          e = rd_q.pop_front();
          if (e.is_rd) chk(bus.wb_data_out === e.val, e.nm, int'(bus.wb_data_out), int'(e.val));
        end
      end
    end
  end

  // TX line monitor: each frame must hold every bit level for exactly tb_p clocks.
  initial begin
    logic [9:0] f;
    int bad, p;
    forever begin
      @(negedge clk);
      if (tx_mon_en && tx_bit === 1'b0) begin
        tx_starts.push_back(cyc);
        p = tb_p;
        if (tx_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected_frame at cycle %0d: no byte queued", cyc);
          repeat (10 * p - 1) @(negedge clk);
        end else begin
          f = {1'b1, tx_exp.pop_front(), 1'b0};
          bad = 0;
          for (int c = 0; c < 10 * p; c++) begin
            if (c > 0) @(negedge clk);
            if (tx_bit !== f[c / p]) bad++;
          end
          chk(bad == 0, "tx_frame_bits", bad, 0);
        end
      end
    end
  end

  task automatic xfer(input logic [1:0] a, input bit we, input logic [7:0] d);
    int n;
    @(negedge clk);
    bus.wb_addr = a; bus.wb_we = we; bus.wb_data_in = d; bus.wb_stb = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.wb_ack !== 1'b1 && n < 8);
    bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    chk(n == 1 && bus.wb_ack === 1'b1, "ack_latency", n, 1);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    rd_q.push_back('{1'b1, e, nm});
    xfer(a, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    rd_q.push_back('{1'b0, 8'h00, "write"});
    xfer(a, 1'b1, d);
  endtask

  task automatic rd_status(input bit tf, input bit te, input bit busy, input string nm);
    logic [7:0] e;
    e = {m_txovf, busy, m_frerr, m_rxovr, rxm.size() == DEPTH, rxm.size() != 0, te, tf};
    rd(2'd1, e, nm);
  endtask

  task automatic rd_data(input string nm);
    logic [7:0] e;
    e = (rxm.size() != 0) ? rxm.pop_front() : 8'h00;
    rd(2'd0, e, nm);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_ok, input int p);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (p) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * p) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int zeros;
    bus.wb_addr = '0; bus.wb_data_in = '0; bus.wb_we = 1'b0; bus.wb_stb = 1'b0;
    repeat (3) @(negedge clk);
    chk(tx_bit === 1'b1, "rst_tx_bit", int'(tx_bit), 1);
    chk(bus.wb_ack === 1'b0, "rst_ack", int'(bus.wb_ack), 0);
    chk(bus.wb_data_out === 8'h00, "rst_data_out", int'(bus.wb_data_out), 0);
    chk(irq === 1'b0, "rst_irq", int'(irq), 0);
    reset_n = 1'b1;

    // Reset register values
    rd_data("rst_data_reg");
    rd_status(1'b0, 1'b1, 1'b0, "rst_status");
    rd(2'd2, 8'h67, "rst_divlo");
    rd(2'd3, 8'h00, "rst_divhi");

    // Back-to-back TX at DIV=7
    wr(2'd2, 8'h07); wr(2'd3, 8'h00);
    rd(2'd2, 8'h07, "divlo_readback");
    tb_p = 8; tx_mon_en = 1; tx_starts.delete();
    tx_exp.push_back(8'hA5); wr(2'd0, 8'hA5);
    tx_exp.push_back(8'h3C); wr(2'd0, 8'h3C);
    repeat (200) @(negedge clk);
    chk(tx_starts.size() == 2, "tx_frame_count", tx_starts.size(), 2);
    if (tx_starts.size() >= 2) chk(tx_starts[1] - tx_starts[0] == 80, "tx_no_gap", tx_starts[1] - tx_starts[0], 80);
    rd_status(1'b0, 1'b1, 1'b0, "tx_done_status");

    // Loopback: 0x5A plus random bytes
    loop_en = 1;
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'h5A : 8'($urandom);
      tx_exp.push_back(b); rxm.push_back(b);
      wr(2'd0, b);
    end
    repeat (380) @(negedge clk);
    chk(irq === 1'b1, "irq_rx_avail", int'(irq), 1);
    rd_status(1'b0, 1'b1, 1'b0, "loop_status");
    for (int i = 0; i < 4; i++) rd_data("loop_data");
    rd_data("loop_empty_read");
    rd_status(1'b0, 1'b1, 1'b0, "loop_drained_status");
    repeat (2) @(negedge clk);
    chk(irq === 1'b0, "irq_cleared", int'(irq), 0);
    chk(tx_exp.size() == 0, "tx_all_sent", tx_exp.size(), 0);
    loop_en = 0; tx_mon_en = 0;

    // TX overflow with the transmitter stalled in a very slow frame
    wr(2'd2, 8'hFF); wr(2'd3, 8'hFF);
    rd(2'd3, 8'hFF, "divhi_readback");
    m_txq = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr(2'd0, 8'($urandom));
      if (i == 0) m_txq = 0;
      else if (m_txq < DEPTH) m_txq++;
      else m_txovf = 1;
    end
    rd_status(m_txq == DEPTH, 1'b0, 1'b1, "txovf_status");
    chk(irq === 1'b1, "irq_txovf", int'(irq), 1);
    wr(2'd1, 8'h80); m_txovf = 0;
    rd_status(m_txq == DEPTH, 1'b0, 1'b1, "txovf_w1c_status");
    chk(irq === 1'b0, "irq_after_w1c", int'(irq), 0);

    // RX overflow, ordering and framing error
    wr(2'd2, 8'h07); wr(2'd3, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, 8);
      if (rxm.size() < DEPTH) rxm.push_back(b);
      else m_rxovr = 1;
    end
    rd_status(m_txq == DEPTH, 1'b0, 1'b1, "rxovr_status");
    for (int i = 0; i < DEPTH; i++) rd_data("rx_order");
    send_rx(8'($urandom), 1'b0, 8);
    m_frerr = 1;
    rd_status(m_txq == DEPTH, 1'b0, 1'b1, "frerr_status");
    rd_data("frerr_no_push");
    wr(2'd1, 8'h30); m_rxovr = 0; m_frerr = 0;
    rd_status(m_txq == DEPTH, 1'b0, 1'b1, "rx_w1c_status");
    chk(irq === 1'b0, "irq_rx_w1c", int'(irq), 0);

    // Reset mid-frame, then a short RX glitch
    chk(tx_bit === 1'b0, "tx_mid_frame", int'(tx_bit), 0);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk(tx_bit === 1'b1, "tx_after_reset", int'(tx_bit), 1);
    rxm.delete(); m_txq = 0; m_txovf = 0; m_rxovr = 0; m_frerr = 0;
    rd_status(1'b0, 1'b1, 1'b0, "post_reset_status");
    rd(2'd2, 8'h67, "post_reset_divlo");
    rd(2'd3, 8'h00, "post_reset_divhi");
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_bit !== 1'b1) zeros++;
    end
    chk(zeros == 0, "tx_idle_after_reset", zeros, 0);
    rd_status(1'b0, 1'b1, 1'b0, "glitch_status");
    rd_data("glitch_no_push");

    repeat (5) @(negedge clk);
    chk(rd_q.size() == 0, "ack_queue_drained", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
